mem2axi: RTL and testbench

MEM2AXI -- requirements
Module: mem2axi

---
 rtl/mem2axi_pkg.sv | 26 ++
 rtl/mem2axi.sv | 213 +++++++++++++++++++++
 tb/tb_mem2axi.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem2axi_pkg.sv
// Shared AXI definitions for the memory/AXI bridges: FSM states, burst and response encodings.
package mem2axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WAIT_B,
        RD_ADDR,
        WAIT_R
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI size encoding is log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/mem2axi.sv
// Bridges a simple req/gnt memory port onto single-beat AXI transactions, one outstanding at a time.
module mem2axi
    import mem2axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 10,
    parameter int AXI_ID         = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   be_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    output logic                          rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic                          err_o,
    output logic [AXI_ID_WIDTH-1:0]       aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    output logic [7:0]                    aw_len,
    output logic [2:0]                    aw_size,
    output logic [1:0]                    aw_burst,
    output logic                          aw_lock,
    output logic [3:0]                    aw_cache,
    output logic [2:0]                    aw_prot,
    output logic [3:0]                    aw_qos,
    output logic [3:0]                    aw_region,
    output logic [5:0]                    aw_atop,
    output logic [AXI_USER_WIDTH-1:0]     aw_user,
    output logic                          aw_valid,
    input  logic                          aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    output logic                          w_last,
    output logic [AXI_USER_WIDTH-1:0]     w_user,
    output logic                          w_valid,
    input  logic                          w_ready,
    input  logic [AXI_ID_WIDTH-1:0]       b_id,
    input  logic [1:0]                    b_resp,
    input  logic [AXI_USER_WIDTH-1:0]     b_user,
    input  logic                          b_valid,
    output logic                          b_ready,
    output logic [AXI_ID_WIDTH-1:0]       ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic                          ar_lock,
    output logic [3:0]                    ar_cache,
    output logic [2:0]                    ar_prot,
    output logic [3:0]                    ar_qos,
    output logic [3:0]                    ar_region,
    output logic [AXI_USER_WIDTH-1:0]     ar_user,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]       r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last,
    input  logic [AXI_USER_WIDTH-1:0]     r_user,
    input  logic                          r_valid,
    output logic                          r_ready
);

    localparam int OFFSET = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((AXI_ADDR_WIDTH'(1) << OFFSET) - AXI_ADDR_WIDTH'(1));
    localparam logic [2:0] SIZE = axi_size(AXI_DATA_WIDTH);

    state_t                        state;
    logic                          we_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH/8-1:0]   be_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q;
    logic                          aw_done;
    logic                          w_done;
    logic                          aw_fin;
    logic                          w_fin;
    logic                          b_hs;
    logic                          r_hs;

    assign aw_fin = aw_done | (aw_valid & aw_ready);
    assign w_fin  = w_done  | (w_valid  & w_ready);
    assign b_hs   = (state == WAIT_B) & b_valid;
    assign r_hs   = (state == WAIT_R) & r_valid;

    // Completion is reported in the response cycle itself so a ready slave gives 2-cycle latency.
    assign gnt_o    = (state == IDLE) & req_i;
    assign rvalid_o = b_hs | r_hs;
    assign err_o    = (b_hs & b_resp[1]) | (r_hs & r_resp[1]);
    assign rdata_o  = r_hs ? r_data : rdata_q;

    assign aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign aw_addr   = addr_q;
    assign aw_len    = '0;
    assign aw_size   = SIZE;
    assign aw_burst  = BURST_INCR;
    assign aw_lock   = 1'b0;
    assign aw_cache  = '0;
    assign aw_prot   = '0;
    assign aw_qos    = '0;
    assign aw_region = '0;
    assign aw_atop   = '0;
    assign aw_user   = '0;
    assign w_data    = wdata_q;
    assign w_strb    = be_q;
    assign w_last    = 1'b1;
    assign w_user    = '0;
    assign ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign ar_addr   = addr_q;
    assign ar_len    = '0;
    assign ar_size   = SIZE;
    assign ar_burst  = BURST_INCR;
    assign ar_lock   = 1'b0;
    assign ar_cache  = '0;
    assign ar_prot   = '0;
    assign ar_qos    = '0;
    assign ar_region = '0;
    assign ar_user   = '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            ar_valid <= 1'b0;
            b_ready  <= 1'b0;
            r_ready  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i & ALIGN_MASK;
                        be_q    <= be_i;
                        wdata_q <= wdata_i;
                        if (we_i) begin
                            state    <= WR_ADDR_DATA;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                        end else begin
                            state    <= RD_ADDR;
                            ar_valid <= 1'b1;
                        end
                    end
                end
                // AW and W complete independently; the done flags remember which one already went.
                WR_ADDR_DATA: begin
                    if (aw_valid && aw_ready) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_valid && w_ready) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state   <= WAIT_B;
                        b_ready <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WAIT_B: begin
                    if (b_valid) begin
                        b_ready <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (r_valid) begin
                        rdata_q <= r_data;
                        r_ready <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    r_last_on_beat: assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid |-> r_last);
    no_stray_b: assert property (@(posedge clk_i) disable iff (!rst_ni) b_valid |-> state == WAIT_B);
    no_stray_r: assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid |-> state == WAIT_R);
    write_state_is_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state == WR_ADDR_DATA) |-> we_q);
    b_fields_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_valid |-> !$isunknown({b_id, b_resp, b_user}));
    r_fields_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_valid |-> !$isunknown({r_id, r_resp, r_user}));
`endif

endmodule

// File: tb/tb_mem2axi.sv
// Directed bench for mem2axi: a hand-driven AXI slave with expected values worked out per cycle.
module tb_mem2axi;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        err_o;
    logic [9:0]  aw_id;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_lock;
    logic [3:0]  aw_cache;
    logic [2:0]  aw_prot;
    logic [3:0]  aw_qos;
    logic [3:0]  aw_region;
    logic [5:0]  aw_atop;
    logic [9:0]  aw_user;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic [9:0]  w_user;
    logic        w_valid;
    logic        w_ready;
    logic [9:0]  b_id;
    logic [1:0]  b_resp;
    logic [9:0]  b_user;
    logic        b_valid;
    logic        b_ready;
    logic [9:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [3:0]  ar_qos;
    logic [3:0]  ar_region;
    logic [9:0]  ar_user;
    logic        ar_valid;
    logic        ar_ready;
    logic [9:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [9:0]  r_user;
    logic        r_valid;
    logic        r_ready;

    int tests = 0;
    int failures = 0;

    mem2axi dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
        .aw_qos(aw_qos), .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_id = '0; b_resp = 2'b00; b_user = '0; b_valid = 1'b0;
        r_id = '0; r_data = '0; r_resp = 2'b00; r_last = 1'b1; r_user = '0; r_valid = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        tests++; if (aw_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_aw_valid: got %b expected 0", aw_valid); end
        tests++; if (w_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_w_valid: got %b expected 0", w_valid); end
        tests++; if (ar_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_ar_valid: got %b expected 0", ar_valid); end
        tests++; if ({b_ready, r_ready} !== 2'b00) begin failures++; $display("[TB] FAIL rst_readies: got %b expected 00", {b_ready, r_ready}); end
        tests++; if ({rvalid_o, err_o} !== 2'b00) begin failures++; $display("[TB] FAIL rst_rvalid_err: got %b expected 00", {rvalid_o, err_o}); end
        tests++; if (rdata_o !== 64'h0) begin failures++; $display("[TB] FAIL rst_rdata: got %h expected 0", rdata_o); end
        tests++; if (gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_gnt: got %b expected 0", gnt_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_write_fast();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h1000; be_i = 8'h0F; wdata_i = 64'hAABBCCDD11223344;
        aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL wr_gnt: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        tests++; if ({aw_valid, w_valid} !== 2'b11) begin failures++; $display("[TB] FAIL wr_valids: got %b expected 11", {aw_valid, w_valid}); end
        tests++; if (aw_addr !== 64'h1000) begin failures++; $display("[TB] FAIL wr_aw_addr: got %h expected 1000", aw_addr); end
        tests++; if (w_strb !== 8'h0F) begin failures++; $display("[TB] FAIL wr_strb: got %h expected 0f", w_strb); end
        tests++; if (w_data !== 64'hAABBCCDD11223344) begin failures++; $display("[TB] FAIL wr_data: got %h expected aabbccdd11223344", w_data); end
        tests++; if ({aw_len, aw_size, aw_burst, w_last} !== {8'd0, 3'd3, 2'b01, 1'b1}) begin failures++; $display("[TB] FAIL wr_burst_fields: got len=%0d size=%0d burst=%b last=%b expected 0 3 01 1", aw_len, aw_size, aw_burst, w_last); end
        tests++; if ({aw_id, aw_lock, aw_cache, aw_prot, aw_atop, aw_user} !== '0) begin failures++; $display("[TB] FAIL wr_const_fields: got id=%h cache=%h prot=%h atop=%h expected all 0", aw_id, aw_cache, aw_prot, aw_atop); end
        tests++; if (rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL wr_early_rvalid: got %b expected 0", rvalid_o); end
        @(negedge clk_i);
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
        #1;
        tests++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin failures++; $display("[TB] FAIL wr_wait_b: got aw/w/b_ready=%b expected 001", {aw_valid, w_valid, b_ready}); end
        tests++; if ({rvalid_o, err_o} !== 2'b10) begin failures++; $display("[TB] FAIL wr_complete: got rvalid/err=%b expected 10", {rvalid_o, err_o}); end
        @(negedge clk_i);
        b_valid = 1'b0;
        #1;
        tests++; if ({rvalid_o, b_ready} !== 2'b00) begin failures++; $display("[TB] FAIL wr_after: got rvalid/b_ready=%b expected 00", {rvalid_o, b_ready}); end
    endtask

    task automatic test_write_w_first();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h1808; be_i = 8'hFF; wdata_i = 64'h0123456789ABCDEF;
        w_ready = 1'b1; aw_ready = 1'b0;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL wf_gnt: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        tests++; if ({aw_valid, w_valid} !== 2'b11) begin failures++; $display("[TB] FAIL wf_valids: got %b expected 11", {aw_valid, w_valid}); end
        @(negedge clk_i);
        w_ready = 1'b0;
        #1;
        tests++; if ({aw_valid, w_valid} !== 2'b10) begin failures++; $display("[TB] FAIL wf_w_dropped: got aw/w=%b expected 10", {aw_valid, w_valid}); end
        @(negedge clk_i);
        #1;
        tests++; if ({aw_valid, w_valid, b_ready} !== 3'b100) begin failures++; $display("[TB] FAIL wf_aw_holds: got aw/w/b_ready=%b expected 100", {aw_valid, w_valid, b_ready}); end
        tests++; if (aw_addr !== 64'h1808) begin failures++; $display("[TB] FAIL wf_aw_addr: got %h expected 1808", aw_addr); end
        @(negedge clk_i);
        aw_ready = 1'b1;
        #1;
        tests++; if ({aw_valid, b_ready} !== 2'b10) begin failures++; $display("[TB] FAIL wf_aw_hs_cycle: got aw/b_ready=%b expected 10", {aw_valid, b_ready}); end
        @(negedge clk_i);
        aw_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b10;
        #1;
        tests++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin failures++; $display("[TB] FAIL wf_wait_b: got aw/w/b_ready=%b expected 001", {aw_valid, w_valid, b_ready}); end
        tests++; if ({rvalid_o, err_o} !== 2'b11) begin failures++; $display("[TB] FAIL wf_slverr: got rvalid/err=%b expected 11", {rvalid_o, err_o}); end
        @(negedge clk_i);
        b_valid = 1'b0; b_resp = 2'b00;
        #1;
        tests++; if ({b_ready, rvalid_o, aw_valid, w_valid} !== 4'b0000) begin failures++; $display("[TB] FAIL wf_one_b: got b_ready/rvalid/aw/w=%b expected 0000", {b_ready, rvalid_o, aw_valid, w_valid}); end
    endtask

    task automatic test_read_delayed();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h2008;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL rd_gnt: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        ar_ready = 1'b1;
        #1;
        tests++; if ({gnt_o, ar_valid} !== 2'b01) begin failures++; $display("[TB] FAIL rd_ar_valid: got gnt/ar_valid=%b expected 01", {gnt_o, ar_valid}); end
        tests++; if (ar_addr !== 64'h2008) begin failures++; $display("[TB] FAIL rd_ar_addr: got %h expected 2008", ar_addr); end
        tests++; if ({ar_len, ar_size, ar_burst, ar_id} !== {8'd0, 3'd3, 2'b01, 10'd0}) begin failures++; $display("[TB] FAIL rd_ar_fields: got len=%0d size=%0d burst=%b id=%h expected 0 3 01 0", ar_len, ar_size, ar_burst, ar_id); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            ar_ready = 1'b0;
            #1;
            tests++; if ({gnt_o, rvalid_o, ar_valid, r_ready} !== 4'b0001) begin failures++; $display("[TB] FAIL rd_wait_%0d: got gnt/rvalid/ar_valid/r_ready=%b expected 0001", i, {gnt_o, rvalid_o, ar_valid, r_ready}); end
        end
        @(negedge clk_i);
        r_valid = 1'b1; r_data = 64'h55; r_resp = 2'b00;
        #1;
        tests++; if ({rvalid_o, err_o, gnt_o} !== 3'b100) begin failures++; $display("[TB] FAIL rd_complete: got rvalid/err/gnt=%b expected 100", {rvalid_o, err_o, gnt_o}); end
        tests++; if (rdata_o !== 64'h55) begin failures++; $display("[TB] FAIL rd_rdata: got %h expected 55", rdata_o); end
        @(negedge clk_i);
        r_valid = 1'b0; r_data = 64'hFFFF; req_i = 1'b0;
        #1;
        tests++; if ({rvalid_o, r_ready} !== 2'b00) begin failures++; $display("[TB] FAIL rd_after: got rvalid/r_ready=%b expected 00", {rvalid_o, r_ready}); end
        tests++; if (rdata_o !== 64'h55) begin failures++; $display("[TB] FAIL rd_hold: got %h expected 55", rdata_o); end
    endtask

    task automatic test_unaligned();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h2003;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL ua_gnt: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        req_i = 1'b0; ar_ready = 1'b1;
        #1;
        tests++; if (ar_addr !== 64'h2000) begin failures++; $display("[TB] FAIL ua_ar_addr: got %h expected 2000", ar_addr); end
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'hCAFE00001234; r_resp = 2'b00;
        #1;
        tests++; if ({rvalid_o, err_o} !== 2'b10) begin failures++; $display("[TB] FAIL ua_latency: got rvalid/err=%b expected 10", {rvalid_o, err_o}); end
        tests++; if (rdata_o !== 64'hCAFE00001234) begin failures++; $display("[TB] FAIL ua_rdata: got %h expected cafe00001234", rdata_o); end
        @(negedge clk_i);
        r_valid = 1'b0;
        #1;
        tests++; if (rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL ua_after: got %b expected 0", rvalid_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h3000;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL bb_gnt0: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        req_i = 1'b0; ar_ready = 1'b1;
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'hDEAD; r_resp = 2'b10;
        #1;
        tests++; if ({rvalid_o, err_o} !== 2'b11) begin failures++; $display("[TB] FAIL bb_slverr: got rvalid/err=%b expected 11", {rvalid_o, err_o}); end
        tests++; if (rdata_o !== 64'hDEAD) begin failures++; $display("[TB] FAIL bb_rdata0: got %h expected dead", rdata_o); end
        @(negedge clk_i);
        r_valid = 1'b0; r_resp = 2'b00; req_i = 1'b1; addr_i = 64'h3010;
        #1;
        tests++; if ({gnt_o, rvalid_o, err_o} !== 3'b100) begin failures++; $display("[TB] FAIL bb_regrant: got gnt/rvalid/err=%b expected 100", {gnt_o, rvalid_o, err_o}); end
        tests++; if (rdata_o !== 64'hDEAD) begin failures++; $display("[TB] FAIL bb_hold: got %h expected dead", rdata_o); end
        @(negedge clk_i);
        req_i = 1'b0; ar_ready = 1'b1;
        #1;
        tests++; if (ar_addr !== 64'h3010) begin failures++; $display("[TB] FAIL bb_ar_addr: got %h expected 3010", ar_addr); end
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h77; r_resp = 2'b00;
        #1;
        tests++; if ({rvalid_o, err_o} !== 2'b10) begin failures++; $display("[TB] FAIL bb_okay: got rvalid/err=%b expected 10", {rvalid_o, err_o}); end
        tests++; if (rdata_o !== 64'h77) begin failures++; $display("[TB] FAIL bb_rdata1: got %h expected 77", rdata_o); end
        @(negedge clk_i);
        r_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait_b();
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h4000; be_i = 8'h3C; wdata_i = 64'h1111;
        aw_ready = 1'b1; w_ready = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        aw_ready = 1'b0; w_ready = 1'b0;
        #1;
        tests++; if (b_ready !== 1'b1) begin failures++; $display("[TB] FAIL rw_in_wait_b: got b_ready=%b expected 1", b_ready); end
        rst_ni = 1'b0;
        #1;
        tests++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready} !== 5'b00000) begin failures++; $display("[TB] FAIL rw_valids: got aw/w/ar/b/r=%b expected 00000", {aw_valid, w_valid, ar_valid, b_ready, r_ready}); end
        tests++; if ({rvalid_o, err_o} !== 2'b00) begin failures++; $display("[TB] FAIL rw_rvalid_err: got %b expected 00", {rvalid_o, err_o}); end
        tests++; if ({rdata_o, w_strb, aw_addr} !== '0) begin failures++; $display("[TB] FAIL rw_regs: got rdata=%h strb=%h addr=%h expected 0", rdata_o, w_strb, aw_addr); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h4010;
        #1;
        tests++; if (gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL rw_regrant: got %b expected 1", gnt_o); end
        @(negedge clk_i);
        req_i = 1'b0; ar_ready = 1'b1;
        #1;
        tests++; if ({ar_valid, aw_valid} !== 2'b10) begin failures++; $display("[TB] FAIL rw_read_issue: got ar/aw=%b expected 10", {ar_valid, aw_valid}); end
        @(negedge clk_i);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h99;
        #1;
        tests++; if ({rvalid_o, rdata_o} !== {1'b1, 64'h99}) begin failures++; $display("[TB] FAIL rw_read_done: got rvalid=%b rdata=%h expected 1 99", rvalid_o, rdata_o); end
        @(negedge clk_i);
        r_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_write_w_first();
        test_read_delayed();
        test_unaligned();
        test_back_to_back();
        test_reset_in_wait_b();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
